lsu: RTL and testbench

Load/store unit for the Pillar core: the initiator that drives the single-port word-addressed data RAM. It accepts byte, halfword and word load/store requests from the execute stage, converts them to word accesses, performs read-modify-write for sub-word stores, and sign- or zero-extends load data. It returns exactly one response per request and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/pillar_mem_pkg.sv | 20 ++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu.sv | 123 ++++++++++++
 tb/tb_lsu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pillar_mem_pkg.sv
// rtl/pillar_mem_pkg.sv - shared size encodings, LSU state type and word-index width
package pillar_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // Byte address bits above the in-word offset
  localparam int WIDX_W = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MRG,
    ST_WR,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extract/extend and store lane merge for sub-word accesses
module lsu_align
  import pillar_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  assign sh_b   = {addr_lo, 3'b000};
  assign sh_h   = {addr_lo[1], 4'b0000};
  assign lane8  = 8'(rdata >> sh_b);
  assign lane16 = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (size)
      SIZE_B:  load_data = is_unsigned ? {24'b0, lane8}  : {{24{lane8[7]}}, lane8};
      SIZE_H:  load_data = is_unsigned ? {16'b0, lane16} : {{16{lane16[15]}}, lane16};
      default: load_data = rdata;
    endcase
  end

  // Full-word stores never reach the merge path, so they pass wdata through
  always_comb begin
    store_data = wdata;
    case (size)
      SIZE_B:  store_data = (rdata & ~(32'h0000_00ff << sh_b)) | ((wdata & 32'h0000_00ff) << sh_b);
      SIZE_H:  store_data = (rdata & ~(32'h0000_ffff << sh_h)) | ((wdata & 32'h0000_ffff) << sh_h);
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit driving the single-port word-addressed data RAM
module lsu
  import pillar_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t state, state_nxt;

  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [1:0]        lo_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       addr_q;
  logic              fault;
  logic              accept;
  logic [WIDX_W-1:0] widx;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  assign widx      = req_addr[31:2];
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    fault = (req_size == SIZE_X)
          || (req_size == SIZE_H && req_addr[0])
          || (req_size == SIZE_W && req_addr[1:0] != 2'b00)
          || ({2'b00, widx} >= 32'(MEM_DEPTH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (fault)                          state_nxt = ST_RESP;
          else if (req_we && req_size == SIZE_W) state_nxt = ST_WR;
          else                                state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = ST_MRG;
      ST_MRG:  state_nxt = ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Faulting requests leave mem_addr at the last real access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_B;
      lo_q    <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      err_q   <= fault;
      size_q  <= req_size;
      lo_q    <= req_addr[1:0];
      wdata_q <= req_wdata;
      rdata_q <= '0;
      if (!fault) addr_q <= {2'b00, widx};
    end else if (state == ST_MRG && !we_q) begin
      rdata_q <= load_data;
    end
  end

  lsu_align u_align (
    .addr_lo     (lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_data  (merge_data)
  );

  // Write strobes are decoded from state so a reset drops a pending RMW write at once
  always_comb begin
    mem_we    = (state == ST_WR) || (state == ST_MRG && we_q);
    mem_wdata = '0;
    if (state == ST_WR)              mem_wdata = wdata_q;
    else if (state == ST_MRG && we_q) mem_wdata = merge_data;
  end

  assign mem_addr  = addr_q;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = (state == ST_RESP) && err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized and directed bench for lsu against a byte-level memory model
module tb_lsu;
  import pillar_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  logic [31:0] ram [0:65535];
  logic [7:0]  refb [0:511];
  logic [31:0] last_rd;

  lsu #(.MEM_DEPTH(65536)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[15:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int b;
    b = int'(a[8:0]);
    if (sz == SIZE_B) begin
      v = {24'b0, refb[b]};
      if (!uns && v[7]) v = v + 32'hFFFF_FF00;
    end else if (sz == SIZE_H) begin
      v = {16'b0, refb[b+1], refb[b]};
      if (!uns && v[15]) v = v + 32'hFFFF_0000;
    end else begin
      v = {refb[b+3], refb[b+2], refb[b+1], refb[b]};
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int b;
    int n;
    b = int'(a[8:0]);
    n = (sz == SIZE_B) ? 1 : (sz == SIZE_H) ? 2 : 4;
    for (int i = 0; i < n; i++) refb[b+i] = 8'((d >> (8*i)) & 32'hFF);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic keep, input logic chk_gap);
    logic        flt;
    int          lat, waitn, rsp_at, mwe_n, mwe_at, ready_hi, exp_mwe_at;
    logic [31:0] exp_rd, got_rd, addr_seen;
    logic        got_err;
    flt = (sz == 2'b11) || (sz == SIZE_H && a[0]) || (sz == SIZE_W && a[1:0] != 2'b00)
          || ((a >> 2) >= 32'd65536);
    if (flt)               lat = 1;
    else if (!we)          lat = 3;
    else if (sz == SIZE_W) lat = 2;
    else                   lat = 3;
    exp_mwe_at = (flt || !we) ? 0 : (sz == SIZE_W) ? 1 : 2;
    exp_rd = (!flt && !we) ? model_load(a, sz, uns) : 32'h0;

    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    waitn = 1;
    while (!req_ready && waitn < 20) begin
      @(negedge clk);
      waitn++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (chk_gap) check("b2b_gap", 32'(waitn), 32'd1);
    @(posedge clk);

    rsp_at = 0; mwe_n = 0; mwe_at = 0; ready_hi = 0;
    got_rd = '0; got_err = 1'b0; addr_seen = '0;
    for (int c = 1; c <= 8 && rsp_at == 0; c++) begin
      @(negedge clk);
      if (c == 1 && !keep) req_valid = 1'b0;
      if (c == 1) addr_seen = mem_addr;
      if (req_ready) ready_hi++;
      if (mem_we) begin
        mwe_n++;
        mwe_at = c;
      end
      if (rsp_valid) begin
        rsp_at  = c;
        got_rd  = rsp_rdata;
        got_err = rsp_err;
      end
    end
    check("latency", 32'(rsp_at), 32'(lat));
    check("rsp_err", 32'(got_err), 32'(flt));
    check("rsp_rdata", got_rd, exp_rd);
    check("mem_we_count", 32'(mwe_n), (flt || !we) ? 32'd0 : 32'd1);
    check("mem_we_cycle", 32'(mwe_at), 32'(exp_mwe_at));
    check("ready_low", 32'(ready_hi), 32'd0);
    if (!flt) check("mem_addr", addr_seen, a >> 2);
    if (!flt && we) model_store(a, sz, d);
    last_rd = got_rd;
  endtask

  task automatic rand_req(input logic keep, input logic chk_gap);
    logic [1:0]  sz;
    logic [31:0] a;
    int          s;
    s  = $urandom_range(0, 9);
    sz = (s < 3) ? SIZE_B : (s < 6) ? SIZE_H : (s < 9) ? SIZE_W : 2'b11;
    a  = $urandom_range(0, 511);
    if ($urandom_range(0, 5) != 0) begin
      if (sz == SIZE_H) a = a & ~32'd1;
      if (sz == SIZE_W) a = a & ~32'd3;
    end
    if ($urandom_range(0, 15) == 0) a = a | 32'h0004_0000;
    do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, keep, chk_gap);
  endtask

  initial begin
    int          rvcnt;
    int          diffs;
    logic [31:0] v;
    for (int w = 0; w < 128; w++) begin
      v = $urandom;
      ram[w] = v;
      for (int i = 0; i < 4; i++) refb[4*w+i] = 8'(v >> (8*i));
    end

    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_req(1'b1, SIZE_W, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_req(1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    check("word_load_value", last_rd, 32'hDEAD_BEEF);

    do_req(1'b1, SIZE_W, 1'b0, 32'h100, 32'h1122_3344, 1'b0, 1'b0);
    do_req(1'b1, SIZE_B, 1'b0, 32'h102, 32'h0000_00AA, 1'b0, 1'b0);
    check("byte_merge_ram", ram[16'h40], 32'h11AA_3344);

    do_req(1'b1, SIZE_W, 1'b0, 32'h100, 32'h8022_3344, 1'b0, 1'b0);
    do_req(1'b0, SIZE_B, 1'b0, 32'h103, 32'h0, 1'b0, 1'b0);
    check("lb_signed", last_rd, 32'hFFFF_FF80);
    do_req(1'b0, SIZE_B, 1'b1, 32'h103, 32'h0, 1'b0, 1'b0);
    check("lb_unsigned", last_rd, 32'h0000_0080);
    do_req(1'b0, SIZE_H, 1'b0, 32'h102, 32'h0, 1'b0, 1'b0);
    check("lh_signed", last_rd, 32'hFFFF_8022);

    do_req(1'b0, SIZE_H, 1'b0, 32'h101, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, SIZE_W, 1'b0, 32'h102, 32'h1234_5678, 1'b0, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, SIZE_W, 1'b0, 32'h0004_0000, 32'h1234_5678, 1'b0, 1'b0);

    rand_req(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) rand_req(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) rand_req(1'b0, 1'b0);

    @(negedge clk);
    req_we = 1'b1; req_size = SIZE_B; req_unsigned = 1'b0;
    req_addr = 32'h104; req_wdata = 32'h0000_0055; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_rmw_we", 32'(mem_we), 32'd1);
    reset = 1'b0;
    rvcnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) rvcnt++;
      if (mem_we) rvcnt++;
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (rsp_valid) rvcnt++;
    end
    check("rst_mid_no_rsp", 32'(rvcnt), 32'd0);
    check("rst_mid_ram", ram[16'h41], model_word(32'h41));
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_mem_addr", mem_addr, 32'd0);

    do_req(1'b0, SIZE_W, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0);

    diffs = 0;
    for (int w = 0; w < 128; w++) if (ram[w] !== model_word(w)) diffs++;
    check("ram_vs_model", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
